// File: rtl/axis_vae_result_streamer_pkg.sv
// ============================================================================
// Module   : vae_pkg
// Purpose  : Shared types and constants for the VAE stream loader/streamer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vae_pkg;

  // Result format: signed Q6.10
  localparam int DATA_W  = 16;
  localparam int FRAC_W  = 10;

  // Stream and BRAM geometry
  localparam int AXIS_W  = 64;
  localparam int ADDR_W  = 4;
  localparam int N_OUT   = 9;

  // Lane offset of the 16-bit value inside a 64-bit beat (shared with the loader)
  localparam int RES_LSB = 48;

  typedef logic signed [DATA_W-1:0] q6_10_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } stream_state_t;

endpackage

`default_nettype wire

// File: rtl/axis_vae_result_streamer_fifo.sv
// ============================================================================
// Module   : vae_sync_fifo
// Purpose  : Small synchronous prefetch FIFO with occupancy count.
//            Head is presented combinationally (first-word fall-through).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vae_sync_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 16,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  // A push into a full FIFO is only accepted when the head leaves in the same cycle
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/axis_vae_result_streamer.sv
// ============================================================================
// Module   : axis_vae_result_streamer
// Purpose  : AXI-Stream master that reads a finished VAE output frame from
//            the xout BRAM and sends one Q6.10 result per 64-bit beat.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_vae_result_streamer #(
  parameter int N_OUT  = vae_pkg::N_OUT,
  parameter int DATA_W = vae_pkg::DATA_W,
  parameter int AXIS_W = vae_pkg::AXIS_W,
  parameter int ADDR_W = vae_pkg::ADDR_W,
  parameter int RD_LAT = 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              vae_done,
  output logic              xout_enb,
  output logic [ADDR_W-1:0] xout_addrb,
  input  logic [DATA_W-1:0] xout_doutb,
  output logic [AXIS_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              frame_done,
  output logic              start_lost
);

  import vae_pkg::*;

  // Prefetch depth: enough to cover the BRAM round trip at full rate
  localparam int D     = RD_LAT + 1;
  localparam int CNT_W = $clog2(D + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_OUT - 1);

  stream_state_t     state;
  logic [ADDR_W-1:0] rd_cnt;
  logic [ADDR_W-1:0] beat_cnt;
  logic [RD_LAT-1:0] rd_vld;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              pop;
  logic              issue;
  logic              last_beat;

  assign pop           = m_axis_tvalid && m_axis_tready;
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tlast  = m_axis_tvalid && (beat_cnt == LAST_IDX);
  assign last_beat     = pop && (beat_cnt == LAST_IDX);
  assign xout_enb      = issue;
  assign xout_addrb    = rd_cnt;

  // Credit check: a read may issue only if every word already in flight plus
  // the FIFO contents, less the head leaving this cycle, leaves a free slot.
  always_comb begin
    issue = 1'b0;
    if (state == ST_READ &&
        (int'(fifo_count) + $countones(rd_vld) - int'(pop)) < D)
      issue = 1'b1;
  end

  // Place the result in the top lane of the beat, lower bits zero
  always_comb begin
    m_axis_tdata = '0;
    m_axis_tdata[RES_LSB +: DATA_W] = fifo_head;
  end

  // Valid tag travelling alongside each read through the BRAM pipeline
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_vld <= '0;
    end else begin
      rd_vld[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) rd_vld[i] <= rd_vld[i-1];
    end
  end

  vae_sync_fifo #(
    .DEPTH (D),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (aclk),
    .rst_n     (aresetn),
    .push      (rd_vld[RD_LAT-1]),
    .push_data (xout_doutb),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // Frame sequencer with registered status outputs; a vae_done seen while a
  // frame is active or during the frame_done cycle is flagged, never started.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= ST_IDLE;
      rd_cnt     <= '0;
      beat_cnt   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      start_lost <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (pop) beat_cnt <= beat_cnt + ADDR_W'(1);
      if (vae_done && (state != ST_IDLE || frame_done)) start_lost <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (vae_done && !frame_done) begin
            state    <= ST_READ;
            rd_cnt   <= '0;
            beat_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        ST_READ: begin
          if (issue) begin
            if (rd_cnt == LAST_IDX) state <= ST_DRAIN;
            else                    rd_cnt <= rd_cnt + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          if (last_beat) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axis_vae_result_streamer.sv
// ============================================================================
// Module   : tb_axis_vae_result_streamer
// Purpose  : Self-checking bench; runs RD_LAT=1 and RD_LAT=2 builds side by
//            side on shared stimulus and compares against a frame model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_vae_result_streamer;

  localparam int N = 9;

  typedef struct {
    int mode;          // 0 ready high, 1 toggle, 2 random, 3 low 20 cycles
    int rand_data;
    int restart_beat;  // -1: none
    int reset_beat;    // -1: none
    int exp_lost;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vae_done = 1'b0;
  logic tready = 1'b0;

  logic [15:0] mem [16];
  logic [15:0] fixed_d [N];

  logic [1:0]        enb;
  logic [1:0][3:0]   addr;
  logic [1:0][15:0]  dout;
  logic [1:0][63:0]  tdata;
  logic [1:0]        tvalid, tlast, busy, fdone, lost;
  logic [15:0]       pipe1;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // monitor state, per instance
  int          beat_n [2];
  logic [63:0] bdata [2][64];
  logic        blast [2][64];
  int          fd_n [2], stall_err [2], over_err [2], addr_err [2];
  int          issued [2], popped [2], lat [2], t0 [2], hs_first [2], hs_last [2];
  logic        started [2], prev_stall [2], prev_last [2];
  logic [63:0] prev_data [2];

  vec_t vecs [9];

  always #5 clk = ~clk;

  axis_vae_result_streamer #(.RD_LAT(1)) u_dut_lat1 (
    .aclk(clk), .aresetn(rst_n), .vae_done(vae_done),
    .xout_enb(enb[0]), .xout_addrb(addr[0]), .xout_doutb(dout[0]),
    .m_axis_tdata(tdata[0]), .m_axis_tvalid(tvalid[0]), .m_axis_tready(tready),
    .m_axis_tlast(tlast[0]), .busy(busy[0]), .frame_done(fdone[0]), .start_lost(lost[0])
  );

  axis_vae_result_streamer #(.RD_LAT(2)) u_dut_lat2 (
    .aclk(clk), .aresetn(rst_n), .vae_done(vae_done),
    .xout_enb(enb[1]), .xout_addrb(addr[1]), .xout_doutb(dout[1]),
    .m_axis_tdata(tdata[1]), .m_axis_tvalid(tvalid[1]), .m_axis_tready(tready),
    .m_axis_tlast(tlast[1]), .busy(busy[1]), .frame_done(fdone[1]), .start_lost(lost[1])
  );

  // BRAM models: one-cycle and two-cycle read latency
  always @(posedge clk) begin
    if (enb[0]) dout[0] <= mem[addr[0]];
    if (enb[1]) pipe1 <= mem[addr[1]];
    dout[1] <= pipe1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Observe both instances away from the active edge
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        beat_n[i] <= 0; fd_n[i] <= 0; stall_err[i] <= 0; over_err[i] <= 0;
        addr_err[i] <= 0; issued[i] <= 0; popped[i] <= 0; lat[i] <= -1;
        t0[i] <= 0; hs_first[i] <= 0; hs_last[i] <= 0; started[i] <= 1'b0;
        prev_stall[i] <= 1'b0; prev_last[i] <= 1'b0; prev_data[i] <= '0;
      end else begin
        if (vae_done && !started[i]) begin
          started[i] <= 1'b1;
          t0[i] <= cyc;
        end
        if (started[i] && lat[i] < 0 && tvalid[i]) lat[i] <= cyc - t0[i] - 1;
        if (prev_stall[i] && (!tvalid[i] || tdata[i] != prev_data[i] || tlast[i] != prev_last[i]))
          stall_err[i] <= stall_err[i] + 1;
        prev_stall[i] <= tvalid[i] && !tready;
        prev_data[i]  <= tdata[i];
        prev_last[i]  <= tlast[i];
        if (enb[i] && int'(addr[i]) >= N) addr_err[i] <= addr_err[i] + 1;
        issued[i] <= issued[i] + int'(enb[i]);
        popped[i] <= popped[i] + int'(tvalid[i] && tready);
        if ((issued[i] + int'(enb[i])) - (popped[i] + int'(tvalid[i] && tready)) > i + 2)
          over_err[i] <= over_err[i] + 1;
        if (tvalid[i] && tready) begin
          if (beat_n[i] < 64) begin
            bdata[i][beat_n[i]] <= tdata[i];
            blast[i][beat_n[i]] <= tlast[i];
          end
          if (beat_n[i] == 0) hs_first[i] <= cyc;
          hs_last[i] <= cyc;
          beat_n[i] <= beat_n[i] + 1;
        end
        if (fdone[i]) fd_n[i] <= fd_n[i] + 1;
      end
    end
  end

  task automatic check(input string name, input int vi, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (vec %0d): got %h, expected %h", name, vi, act, exp);
  endtask

  function automatic logic rdy(input int mode, input int c);
    case (mode)
      0: return 1'b1;
      1: return (c % 6 == 0) || (c % 6 == 3) || (c % 6 == 5);
      2: return $urandom_range(0, 3) != 0;
      default: return c > 20;
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    vae_done = 1'b0;
    tready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_reset_vals(input int vi);
    for (int i = 0; i < 2; i++) begin
      check("rst_enb", vi, 64'(enb[i]), 64'd0);
      check("rst_addr", vi, 64'(addr[i]), 64'd0);
      check("rst_tvalid", vi, 64'(tvalid[i]), 64'd0);
      check("rst_tlast", vi, 64'(tlast[i]), 64'd0);
      check("rst_tdata", vi, tdata[i], 64'd0);
      check("rst_busy", vi, 64'(busy[i]), 64'd0);
      check("rst_frame_done", vi, 64'(fdone[i]), 64'd0);
      check("rst_start_lost", vi, 64'(lost[i]), 64'd0);
    end
  endtask

  task automatic run_vec(input int vi);
    vec_t v;
    int   tail;
    logic done, restarted;
    v = vecs[vi];
    do_reset();
    for (int k = 0; k < 16; k++)
      mem[k] = (k >= N) ? 16'hDEAD : (v.rand_data != 0 ? 16'($urandom) : fixed_d[k]);

    // Optional aborted frame: async reset after a few beats
    if (v.reset_beat >= 0) begin
      @(posedge clk); #1 vae_done = 1'b1; tready = 1'b1;
      @(posedge clk); #1 vae_done = 1'b0;
      for (int c = 0; c < 200 && beat_n[0] < v.reset_beat; c++) begin
        @(posedge clk); #1;
      end
      #2 rst_n = 1'b0;
      #1 check_reset_vals(vi);
      tready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
    end

    @(posedge clk); #1 vae_done = 1'b1; tready = rdy(v.mode, 0);
    done = 1'b0; restarted = 1'b0; tail = 0;
    for (int c = 1; c < 600 && !done; c++) begin
      @(posedge clk); #1;
      vae_done = 1'b0;
      if (v.mode == 3 && c == 21) begin
        for (int i = 0; i < 2; i++) begin
          check("held_reads", vi, 64'(issued[i]), 64'(i + 2));
          check("held_beats", vi, 64'(beat_n[i]), 64'd0);
          check("held_tvalid", vi, 64'(tvalid[i]), 64'd1);
          check("held_tdata", vi, tdata[i], {fixed_d[0], 48'h0});
        end
      end
      tready = rdy(v.mode, c);
      if (v.restart_beat >= 0 && !restarted && beat_n[0] >= v.restart_beat) begin
        vae_done = 1'b1;
        restarted = 1'b1;
      end
      if (fd_n[0] >= 1 && fd_n[1] >= 1) tail++;
      if (tail >= 20) done = 1'b1;
    end
    vae_done = 1'b0;
    check("timeout", vi, 64'(done), 64'd1);

    // Compare against the frame model: beat k carries xout[k] in the top lane
    for (int i = 0; i < 2; i++) begin
      check("beat_count", vi, 64'(beat_n[i]), 64'(N));
      for (int k = 0; k < N && k < beat_n[i]; k++) begin
        check("beat_data", vi, bdata[i][k], {mem[k], 48'h0});
        check("beat_last", vi, 64'(blast[i][k]), 64'(k == N - 1));
      end
      check("frame_done_count", vi, 64'(fd_n[i]), 64'd1);
      check("stall_stability", vi, 64'(stall_err[i]), 64'd0);
      check("outstanding_reads", vi, 64'(over_err[i]), 64'd0);
      check("addr_range", vi, 64'(addr_err[i]), 64'd0);
      check("start_lost", vi, 64'(lost[i]), 64'(v.exp_lost));
      check("busy_end", vi, 64'(busy[i]), 64'd0);
      check("first_valid_latency", vi, 64'(lat[i]), 64'(i + 2));
      if (v.mode == 0 && v.restart_beat < 0)
        check("throughput", vi, 64'(hs_last[i] - hs_first[i]), 64'(N - 1));
    end
  endtask

  initial begin
    fixed_d = '{16'h0400, 16'hFC00, 16'h0001, 16'h7FFF, 16'h8000,
                16'h0000, 16'h0A3D, 16'hFFFF, 16'h1234};
    for (int k = 0; k < 16; k++) mem[k] = 16'h0;
    //           mode rand restart reset lost
    vecs[0] = '{0, 0, -1, -1, 0};  // basic frame
    vecs[1] = '{1, 0, -1, -1, 0};  // toggling backpressure
    vecs[2] = '{3, 0, -1, -1, 0};  // tready low for 20 cycles
    vecs[3] = '{2, 1, -1, -1, 0};  // random data, random ready
    vecs[4] = '{2, 1, -1, -1, 0};
    vecs[5] = '{0, 0,  4, -1, 1};  // restart at beat 4
    vecs[6] = '{0, 0,  9, -1, 1};  // restart coincident with frame_done
    vecs[7] = '{2, 1,  4, -1, 1};
    vecs[8] = '{0, 0, -1,  4, 0};  // reset after beat 3, then fresh frame

    do_reset();
    check_reset_vals(-1);
    for (int vi = 0; vi < 9; vi++) run_vec(vi);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axis_vae_result_streamer.md
Name: axis_vae_result_streamer

Overview:
- AXI-Stream master (transmit) end of the VAE accelerator. After the VAE core pulses vae_done, it reads the reconstructed-output BRAM (xout, port B) and streams each 16-bit Q6.10 result to the host DMA (S2MM), one result per 64-bit beat, with tlast on the final beat.
- Mirrors the slave-side loader, which accepts one 16-bit input per beat in bits [63:48].

Parameters:
- N_OUT, 9, number of results per frame.
- DATA_W, 16, result width (signed Q6.10).
- AXIS_W, 64, stream width.
- ADDR_W, 4, xout BRAM address width.
- RD_LAT, 1, xout BRAM read latency in cycles; legal values are 1 and 2.

Ports:
- aclk  in  1  clock; all logic rising-edge.
- aresetn  in  1  asynchronous, active-low reset.
- vae_done  in  1  single-cycle pulse from the VAE core: the xout frame is valid.
- xout_enb  out  1  BRAM port-B enable.
- xout_addrb  out  ADDR_W  BRAM port-B read address.
- xout_doutb  in  DATA_W  BRAM read data, valid RD_LAT cycles after an enabled address.
- m_axis_tdata  out  AXIS_W  {result, 48'b0}.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  asserted on beat N_OUT-1.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last beat handshakes.
- start_lost  out  1  sticky: vae_done arrived while busy.

Behaviour:
- Reset values: xout_enb=0, xout_addrb=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, frame_done=0, start_lost=0. Reset also clears all counters and the FIFO. Reset mid-frame abandons the frame; no partial tlast is emitted.
- FSM states:
  - IDLE: busy=0. vae_done moves to READ, with rd_cnt=0 and beat_cnt=0.
  - READ: issue read rd_cnt (xout_enb=1, xout_addrb=rd_cnt) only when the number of outstanding reads plus FIFO occupancy is less than FIFO depth D=RD_LAT+1. When rd_cnt reaches N_OUT-1 and is issued, move to DRAIN.
  - DRAIN: wait until the last beat handshakes, then return to IDLE. In the same cycle, pulse frame_done for one cycle.
- Read pipeline: an RD_LAT-deep valid shift register tags returning data. Each returning word is pushed into the D-entry prefetch FIFO. The credit rule guarantees no overflow, so no data is ever dropped under backpressure.
- Output path:
  - m_axis_tvalid = FIFO not empty.
  - tdata[63:48] = FIFO head; tdata[47:0] = 0. The result passes bit-exact, with no sign extension or rounding.
  - Pop only on tvalid && tready.
  - tdata, tvalid and tlast hold stable while tvalid=1 and tready=0 (AXI-Stream rule).
- tlast = tvalid && (beat_cnt == N_OUT-1). beat_cnt increments on each handshake.
- Throughput: with tready held high, 1 beat per cycle after the pipeline fills.
- Latency: the first tvalid asserts RD_LAT+1 cycles after the vae_done cycle.
- Simultaneous events: FIFO push and pop in the same cycle is legal and occupancy is unchanged. A vae_done in the same cycle as frame_done (FSM leaving DRAIN) is treated as busy: it sets start_lost and starts no new frame.
- start_lost is cleared only by reset.
- Address wrap: rd_cnt never exceeds N_OUT-1. Addresses N_OUT through 2^ADDR_W-1 are never read.

Decomposition:
- Shared package vae_pkg holds:
  - the Q6.10 result typedef (DATA_W, FRAC_W=10);
  - AXIS_W;
  - ADDR_W;
  - N_OUT;
  - the beat-packing lane offset (RES_LSB=48), also used by the slave-side loader.
- One natural sub-module: vae_sync_fifo, a parameterised depth D, width DATA_W synchronous FIFO exposing occupancy count, with async active-low reset.

Test Plan:
- Basic frame:
  - Stimulus: preload xout[0..8] = 0x0400, 0xFC00, 0x0001, 0x7FFF, 0x8000, 0x0000, 0x0A3D, 0xFFFF, 0x1234; tready=1; pulse vae_done.
  - Response: 9 consecutive beats with tdata = {word,48'h0}, tlast only on the 9th (0x1234), then frame_done 1 cycle after the 9th handshake.
- Backpressure:
  - Stimulus: same data; tready toggles 1,0,0,1,0,1,...
  - Response: identical beat sequence; tdata, tvalid and tlast stable during stalls; no more than D reads outstanding; no lost or duplicated beats.
- tready held low:
  - Stimulus: tready=0 for 20 cycles after vae_done, then released.
  - Response: xout_enb stops after D reads; beat 0 = 0x0400 is held; all 9 beats are delivered after release.
- Restart during frame:
  - Stimulus: second vae_done at beat 4.
  - Response: start_lost=1 and remains set; the current frame completes normally; no second frame follows.
- Reset mid-frame:
  - Stimulus: drop aresetn after beat 3.
  - Response: all outputs return to reset values asynchronously. A subsequent vae_done produces a full fresh 9-beat frame starting at xout[0].
- RD_LAT=2 build:
  - Stimulus: repeat the basic-frame scenario.
  - Response: identical beats; first tvalid 3 cycles after vae_done.
